regfile_bist_driver: RTL and testbench

//  Built-in self-test sequencer for the regfile test port, sitting directly upstream of the test-harness top.

---
 rtl/regfile_bist_pkg.sv | 34 +++
 rtl/bist_hold_timer.sv | 29 ++
 rtl/regfile_bist_driver.sv | 155 +++++++++++++++
 tb/tb_regfile_bist_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_bist_pkg.sv
// Shared definitions for the regfile BIST driver: state encoding, widths and pattern helpers.
package regfile_bist_pkg;

  localparam int IDX_W = 5;
  localparam int ERR_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    READ  = ST_READ,
    DONE  = ST_DONE
  } bistState_e;

  // The index is replicated into every byte so a stuck bit anywhere in the word shows up.
  function automatic logic [31:0] patternWord(input logic [31:0] seed,
                                              input logic [IDX_W-1:0] r,
                                              input logic inv);
    logic [31:0] p;
    p = seed ^ {4{3'b000, r}};
    return inv ? ~p : p;
  endfunction

  function automatic logic [31:0] expectedWord(input logic [31:0] seed,
                                               input logic [IDX_W-1:0] r,
                                               input logic inv);
    return (r == '0) ? 32'h0 : patternWord(seed, r, inv);
  endfunction

endpackage

// File: rtl/bist_hold_timer.sv
// Hold-window timer: counts 0..HOLD_CYCLES-1 while running and flags the last cycle of each window.
module bist_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic lastCycle
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || !run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign lastCycle = run && (count == LAST);

endmodule

// File: rtl/regfile_bist_driver.sv
// Regfile BIST sequencer: writes a pattern to r0..r31, reads back on both ports, reports errors.
// Optional REGFILE_BIST_INV_PASS_EN adds a second write/read pass with inverted patterns.
module regfile_bist_driver
  import regfile_bist_pkg::*;
#(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [31:0] SEED        = 32'hA5C3_0F96
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             test,
  output logic             t_ctrl_writeEnable,
  output logic [IDX_W-1:0] t_ctrl_writeReg,
  output logic [IDX_W-1:0] t_ctrl_readRegA,
  output logic [IDX_W-1:0] t_ctrl_readRegB,
  output logic [31:0]      t_data_writeReg,
  input  logic [31:0]      t_data_readRegA,
  input  logic [31:0]      t_data_readRegB,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_reg,
  output logic [31:0]      fail_data,
  output logic [ERR_W-1:0] err_count
);

  bistState_e       state;
  logic [IDX_W-1:0] idx;
  logic             invPass;
  logic             lastCycle;
  logic             startAccept;
  logic [IDX_W-1:0] idxB;
  logic             mismA;
  logic             mismB;
  logic [ERR_W:0]   errSum;
  logic [ERR_W-1:0] errNext;

  bist_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) holdTimer (
    .clock    (clock),
    .reset    (reset),
    .clear    (startAccept),
    .run      (state == WRITE || state == READ),
    .lastCycle(lastCycle)
  );

  // Port B walks the registers in reverse so both read paths see every register once.
  always_comb begin
    startAccept = start && !busy && (state == IDLE || state == DONE);
    idxB        = 5'd31 - idx;
    mismA       = t_data_readRegA != expectedWord(SEED, idx, invPass);
    mismB       = t_data_readRegB != expectedWord(SEED, idxB, invPass);
    errSum      = (ERR_W+1)'(err_count) + (ERR_W+1)'(mismA) + (ERR_W+1)'(mismB);
    errNext     = errSum[ERR_W] ? {ERR_W{1'b1}} : errSum[ERR_W-1:0];
  end

  // Busy stays high through the first DONE cycle so pass can see the final compare's count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      idx                <= '0;
      invPass            <= 1'b0;
      test               <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      fail_reg           <= '0;
      fail_data          <= '0;
      err_count          <= '0;
      t_ctrl_writeEnable <= 1'b0;
      t_ctrl_writeReg    <= '0;
      t_ctrl_readRegA    <= '0;
      t_ctrl_readRegB    <= '0;
      t_data_writeReg    <= '0;
    end else if (startAccept) begin
      state              <= WRITE;
      idx                <= '0;
      invPass            <= 1'b0;
      test               <= 1'b1;
      busy               <= 1'b1;
      done               <= 1'b0;
      pass               <= 1'b0;
      fail_reg           <= '0;
      fail_data          <= '0;
      err_count          <= '0;
      t_ctrl_writeEnable <= 1'b1;
      t_ctrl_writeReg    <= '0;
      t_data_writeReg    <= patternWord(SEED, '0, 1'b0);
    end else begin
      case (state)
        WRITE: begin
          if (lastCycle) begin
            if (idx == 5'd31) begin
              state              <= READ;
              idx                <= '0;
              t_ctrl_writeEnable <= 1'b0;
              t_ctrl_writeReg    <= '0;
              t_data_writeReg    <= '0;
              t_ctrl_readRegA    <= '0;
              t_ctrl_readRegB    <= 5'd31;
            end else begin
              idx             <= idx + 5'd1;
              t_ctrl_writeReg <= idx + 5'd1;
              t_data_writeReg <= patternWord(SEED, idx + 5'd1, invPass);
            end
          end
        end
        READ: begin
          if (lastCycle) begin
            err_count <= errNext;
            if (err_count == '0 && (mismA || mismB)) begin
              fail_reg  <= mismA ? idx : idxB;
              fail_data <= mismA ? t_data_readRegA : t_data_readRegB;
            end
            if (idx == 5'd31) begin
`ifdef REGFILE_BIST_INV_PASS_EN
              if (!invPass) begin
                state              <= WRITE;
                idx                <= '0;
                invPass            <= 1'b1;
                t_ctrl_writeEnable <= 1'b1;
                t_ctrl_writeReg    <= '0;
                t_data_writeReg    <= patternWord(SEED, '0, 1'b1);
                t_ctrl_readRegA    <= '0;
                t_ctrl_readRegB    <= '0;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end else begin
              idx             <= idx + 5'd1;
              t_ctrl_readRegA <= idx + 5'd1;
              t_ctrl_readRegB <= 5'd30 - idx;
            end
          end
        end
        DONE: begin
          if (busy) begin
            busy            <= 1'b0;
            test            <= 1'b0;
            done            <= 1'b1;
            pass            <= (err_count == '0);
            t_ctrl_readRegA <= '0;
            t_ctrl_readRegB <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist_driver.sv
// Self-checking bench for regfile_bist_driver with a behavioural regfile and fault injection.
// Honours REGFILE_BIST_INV_PASS_EN for the two-pass expectations.
module tb_regfile_bist_driver;

  localparam int          H    = 4;
  localparam logic [31:0] SEED = 32'hA5C3_0F96;
`ifdef REGFILE_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int LATENCY = 64 * H * NPASS + 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        test;
  logic        wen;
  logic [4:0]  wreg;
  logic [4:0]  raddrA;
  logic [4:0]  raddrB;
  logic [31:0] wdata;
  logic [31:0] rdataA;
  logic [31:0] rdataB;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  failReg;
  logic [31:0] failData;
  logic [7:0]  errCount;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int startCycle = 0;
  int faultMode = 0;
  logic [31:0] mem [32];
  logic [31:0] lastR5 = '0;

  typedef struct {
    logic        passExp;
    logic [4:0]  failReg;
    logic [31:0] failData;
    logic [7:0]  errCnt;
  } runExp_t;
  runExp_t sb[$];

  regfile_bist_driver #(.HOLD_CYCLES(H), .SEED(SEED)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .test              (test),
    .t_ctrl_writeEnable(wen),
    .t_ctrl_writeReg   (wreg),
    .t_ctrl_readRegA   (raddrA),
    .t_ctrl_readRegB   (raddrB),
    .t_data_writeReg   (wdata),
    .t_data_readRegA   (rdataA),
    .t_data_readRegB   (rdataB),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .fail_reg          (failReg),
    .fail_data         (failData),
    .err_count         (errCount)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Behavioural regfile: r0 hardwired to zero, fault 1 = r7 bit 3 stuck-at-1, fault 2 = r0 reads 1.
  always @(posedge clock) begin
    if (test && wen && wreg != 5'd0) mem[wreg] <= wdata;
  end

  always_comb begin
    rdataA = (raddrA == 5'd0) ? 32'h0 : mem[raddrA];
    rdataB = (raddrB == 5'd0) ? 32'h0 : mem[raddrB];
    if (faultMode == 1 && raddrA == 5'd7) rdataA[3] = 1'b1;
    if (faultMode == 1 && raddrB == 5'd7) rdataB[3] = 1'b1;
    if (faultMode == 2 && raddrA == 5'd0) rdataA = 32'h1;
    if (faultMode == 2 && raddrB == 5'd0) rdataB = 32'h1;
  end

  always @(negedge clock) begin
    if (test && wen && wreg == 5'd5) lastR5 <= wdata;
  end

  function automatic logic [31:0] tbPattern(input int r, input int inv);
    logic [7:0]  b;
    logic [31:0] p;
    b = 8'(r);
    p = SEED ^ {b, b, b, b};
    return (inv != 0) ? ~p : p;
  endfunction

  function automatic logic [31:0] tbExpected(input int r, input int inv);
    return (r == 0) ? 32'h0 : tbPattern(r, inv);
  endfunction

  function automatic logic [31:0] tbObserved(input int r, input int inv, input int fault);
    logic [31:0] v;
    v = tbExpected(r, inv);
    if (fault == 1 && r == 7) v[3] = 1'b1;
    if (fault == 2 && r == 0) v = 32'h1;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Pushes the expected run outcome (when the run should finish) and pulses start.
  task automatic applyStimulus(input int fault, input bit expectDone);
    runExp_t e;
    int errs;
    faultMode = fault;
    if (expectDone) begin
      errs = 0;
      e.failReg = '0;
      e.failData = '0;
      for (int p = 0; p < NPASS; p++) begin
        for (int i = 0; i < 32; i++) begin
          if (tbObserved(i, p, fault) !== tbExpected(i, p)) begin
            if (errs == 0) begin
              e.failReg = 5'(i);
              e.failData = tbObserved(i, p, fault);
            end
            errs++;
          end
          if (tbObserved(31 - i, p, fault) !== tbExpected(31 - i, p)) begin
            if (errs == 0) begin
              e.failReg = 5'(31 - i);
              e.failData = tbObserved(31 - i, p, fault);
            end
            errs++;
          end
        end
      end
      e.errCnt = (errs > 255) ? 8'hFF : 8'(errs);
      e.passExp = (errs == 0);
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b1;
    startCycle = cycle + 1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic checkRun(input string tag);
    runExp_t e;
    int waited;
    waited = 0;
    while (done !== 1'b1 && waited < 4 * LATENCY) begin
      @(negedge clock);
      waited++;
    end
    if (done !== 1'b1) checkOutput({tag, "_doneTimeout"}, 32'(done), 32'h1);
    else checkOutput({tag, "_latency"}, 32'(cycle - startCycle), 32'(LATENCY));
    if (sb.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 32'(sb.size()), 32'h1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_pass"}, 32'(pass), 32'(e.passExp));
      checkOutput({tag, "_errCount"}, 32'(errCount), 32'(e.errCnt));
      checkOutput({tag, "_failReg"}, 32'(failReg), 32'(e.failReg));
      checkOutput({tag, "_failData"}, failData, e.failData);
    end
    checkOutput({tag, "_testLow"}, 32'(test), 32'h0);
    checkOutput({tag, "_busyLow"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    reset = 1'b0;
    start = 1'b0;
    #22;
    checkOutput("rst_status", {27'h0, test, busy, done, pass, 1'b0}, 32'h0);
    checkOutput("rst_ctrl", {16'h0, wen, wreg, raddrA, raddrB}, 32'h0);
    checkOutput("rst_wdata", wdata, 32'h0);
    checkOutput("rst_fail", {19'h0, failReg, errCount}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Fault-free run, plus the last data written to r5.
    applyStimulus(0, 1'b1);
    checkOutput("run1_testHigh", 32'(test), 32'h1);
    checkRun("run1");
`ifdef REGFILE_BIST_INV_PASS_EN
    checkOutput("run1_r5Write", lastR5, ~(SEED ^ 32'h0505_0505));
`else
    checkOutput("run1_r5Write", lastR5, SEED ^ 32'h0505_0505);
`endif

    // Bit 3 of r7's pattern is already 0, so a stuck-at-1 is what exposes that bit.
    applyStimulus(1, 1'b1);
    checkRun("r7fault");

    applyStimulus(2, 1'b1);
    checkRun("r0fault");

    // Abort mid-run: outputs must clear as soon as reset asserts, not at the next edge.
    applyStimulus(0, 1'b0);
    repeat (49) @(negedge clock);
    checkOutput("abort_preTest", 32'(test), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort_status", {27'h0, test, busy, done, pass, 1'b0}, 32'h0);
    checkOutput("abort_ctrl", {16'h0, wen, wreg, raddrA, raddrB}, 32'h0);
    checkOutput("abort_wdata", wdata, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(0, 1'b1);
    checkRun("afterAbort");

    // Extra start pulses while busy must not restart the run.
    applyStimulus(0, 1'b1);
    repeat (9) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (89) @(negedge clock);
    checkOutput("ignore_busy", 32'(busy), 32'h1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkRun("ignoreStart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
